// File: rtl/pmp_fork8_sync.sv
// Fork controller: fans one upstream drive out to up to 8 PMP entry-check branches,
// collects each enabled branch's free in any order, and returns a single free upstream.
module pmp_fork8_sync #(
  parameter int unsigned N_BRANCH = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_drive,
  input  logic [N_BRANCH-1:0] i_branch_en,
  output logic                o_free,
  output logic [N_BRANCH-1:0] o_drive,
  input  logic [N_BRANCH-1:0] i_free,
  output logic                o_busy,
  output logic [N_BRANCH-1:0] o_pending_mask,
  output logic                o_err_timeout,
  output logic                o_err_overrun
);

  if (N_BRANCH != 8) begin : gBadBranchCount
    $error("pmp_fork8_sync: N_BRANCH must be 8");
  end
  if (CNT_W < 1 || CNT_W > 31 || TIMEOUT > (32'd1 << CNT_W) - 32'd1) begin : gBadTimeout
    $error("pmp_fork8_sync: TIMEOUT does not fit in CNT_W bits");
  end

  localparam int unsigned TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
  localparam bit TO_ENABLED = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    StIdle,
    StFork,
    StWait,
    StAck
  } stateT;

  stateT               state;
  logic [N_BRANCH-1:0] enMask;
  logic [N_BRANCH-1:0] collected;
  logic [CNT_W-1:0]    cnt;

  logic [N_BRANCH-1:0] collNext;
  logic                allFreed;
  logic                timeoutHit;

  // Completion looks at this cycle's frees too, so a free in FORK reaches ACK next cycle.
  always_comb begin
    collNext   = collected | (i_free & enMask);
    allFreed   = (collNext == enMask);
    timeoutHit = TO_ENABLED && (cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= StIdle;
      enMask         <= '0;
      collected      <= '0;
      cnt            <= '0;
      o_free         <= 1'b0;
      o_drive        <= '0;
      o_busy         <= 1'b0;
      o_pending_mask <= '0;
      o_err_timeout  <= 1'b0;
      o_err_overrun  <= 1'b0;
    end else begin
      o_free        <= 1'b0;
      o_drive       <= '0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= i_drive && (state != StIdle);

      unique case (state)
        StIdle: begin
          if (i_drive) begin
            enMask         <= i_branch_en;
            collected      <= '0;
            cnt            <= '0;
            o_drive        <= i_branch_en;
            o_busy         <= 1'b1;
            o_pending_mask <= i_branch_en;
            state          <= StFork;
          end
        end

        StFork, StWait: begin
          collected      <= collNext;
          o_pending_mask <= enMask & ~collNext;
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          if (allFreed) begin
            o_free <= 1'b1;
            state  <= StAck;
          end else if (timeoutHit) begin
            o_free        <= 1'b1;
            o_err_timeout <= 1'b1;
            state         <= StAck;
          end else begin
            state <= StWait;
          end
        end

        StAck: begin
          o_busy         <= 1'b0;
          o_pending_mask <= '0;
          state          <= StIdle;
        end

        default: begin
          o_busy         <= 1'b0;
          o_pending_mask <= '0;
          state          <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_fork8_sync.sv
// Directed bench for pmp_fork8_sync with TIMEOUT=16; cycle t is the cycle i_drive is high.
module tb_pmp_fork8_sync;

  logic       clk;
  logic       rstn;
  logic       i_drive;
  logic [7:0] i_branch_en;
  logic       o_free;
  logic [7:0] o_drive;
  logic [7:0] i_free;
  logic       o_busy;
  logic [7:0] o_pending_mask;
  logic       o_err_timeout;
  logic       o_err_overrun;

  int errors = 0;
  int checks = 0;

  pmp_fork8_sync #(
    .N_BRANCH(8),
    .TIMEOUT (16),
    .CNT_W   (8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_drive       (i_drive),
    .i_branch_en   (i_branch_en),
    .o_free        (o_free),
    .o_drive       (o_drive),
    .i_free        (i_free),
    .o_busy        (o_busy),
    .o_pending_mask(o_pending_mask),
    .o_err_timeout (o_err_timeout),
    .o_err_overrun (o_err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the given inputs for the current cycle, then move 1 time unit into the next cycle.
  task automatic cyc(input logic drv, input logic [7:0] en, input logic [7:0] fr);
    i_drive     = drv;
    i_branch_en = en;
    i_free      = fr;
    @(posedge clk);
    #1;
    i_drive     = 1'b0;
    i_branch_en = 8'h00;
    i_free      = 8'h00;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_free"}, {31'd0, o_free}, 32'd0);
    chk({tag, "_drive"}, {24'd0, o_drive}, 32'd0);
    chk({tag, "_pend"}, {24'd0, o_pending_mask}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    i_drive = 1'b0;
    i_branch_en = 8'h00;
    i_free = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chkIdle("rst");
    chk("rst_to", {31'd0, o_err_timeout}, 32'd0);
    chk("rst_ovr", {31'd0, o_err_overrun}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic fork with all frees at t+1, then back-to-back drive at t+3
    cyc(1'b1, 8'hFF, 8'h00);
    chk("basic_drive_t1", {24'd0, o_drive}, 32'hFF);
    chk("basic_busy_t1", {31'd0, o_busy}, 32'd1);
    chk("basic_free_t1", {31'd0, o_free}, 32'd0);
    chk("basic_pend_t1", {24'd0, o_pending_mask}, 32'hFF);
    cyc(1'b0, 8'h00, 8'hFF);
    chk("basic_drive_t2", {24'd0, o_drive}, 32'h00);
    chk("basic_free_t2", {31'd0, o_free}, 32'd1);
    chk("basic_busy_t2", {31'd0, o_busy}, 32'd1);
    chk("basic_to_t2", {31'd0, o_err_timeout}, 32'd0);
    chk("basic_pend_t2", {24'd0, o_pending_mask}, 32'h00);
    cyc(1'b0, 8'h00, 8'h00);
    chkIdle("basic_t3");
    cyc(1'b1, 8'h11, 8'h00);
    chk("turn_drive", {24'd0, o_drive}, 32'h11);
    chk("turn_ovr", {31'd0, o_err_overrun}, 32'd0);
    cyc(1'b0, 8'h00, 8'h11);
    chk("turn_free", {31'd0, o_free}, 32'd1);
    cyc(1'b0, 8'h00, 8'h00);

    // Out-of-order frees on en=A5, duplicate at t+6
    cyc(1'b1, 8'hA5, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    chk("ooo_pend_t3", {24'd0, o_pending_mask}, 32'hA5);
    cyc(1'b0, 8'h00, 8'h01);
    chk("ooo_pend_t4", {24'd0, o_pending_mask}, 32'hA4);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h84);
    chk("ooo_pend_t6", {24'd0, o_pending_mask}, 32'h20);
    cyc(1'b0, 8'h00, 8'h01);
    chk("ooo_pend_dup", {24'd0, o_pending_mask}, 32'h20);
    chk("ooo_free_dup", {31'd0, o_free}, 32'd0);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    chk("ooo_free_t9", {31'd0, o_free}, 32'd0);
    cyc(1'b0, 8'h00, 8'h20);
    chk("ooo_free_t10", {31'd0, o_free}, 32'd1);
    chk("ooo_pend_t10", {24'd0, o_pending_mask}, 32'h00);
    chk("ooo_to_t10", {31'd0, o_err_timeout}, 32'd0);
    cyc(1'b0, 8'h00, 8'h00);
    chkIdle("ooo_t11");

    // Stray frees outside en=0F never complete; the timeout forces completion at t+17
    cyc(1'b1, 8'h0F, 8'h00);
    cyc(1'b0, 8'h00, 8'hF0);
    chk("stray_pend", {24'd0, o_pending_mask}, 32'h0F);
    for (int i = 0; i < 15; i++) begin
      chk("stray_nofree", {31'd0, o_free}, 32'd0);
      cyc(1'b0, 8'h00, 8'hF0);
    end
    chk("stray_free_t17", {31'd0, o_free}, 32'd1);
    chk("stray_to_t17", {31'd0, o_err_timeout}, 32'd1);
    chk("stray_pend_t17", {24'd0, o_pending_mask}, 32'h0F);
    cyc(1'b0, 8'h00, 8'h00);
    chk("stray_to_t18", {31'd0, o_err_timeout}, 32'd0);

    // Empty enable: no branch pulses, o_free at t+2
    cyc(1'b1, 8'h00, 8'h00);
    chk("empty_drive", {24'd0, o_drive}, 32'h00);
    chk("empty_busy", {31'd0, o_busy}, 32'd1);
    chk("empty_free_t1", {31'd0, o_free}, 32'd0);
    cyc(1'b0, 8'h00, 8'h00);
    chk("empty_free_t2", {31'd0, o_free}, 32'd1);
    chk("empty_to_t2", {31'd0, o_err_timeout}, 32'd0);
    cyc(1'b0, 8'h00, 8'h00);
    chkIdle("empty_t3");

    // Timeout with only branch 0 of en=03 freeing
    cyc(1'b1, 8'h03, 8'h00);
    cyc(1'b0, 8'h00, 8'h01);
    for (int i = 0; i < 15; i++) begin
      chk("to_nofree", {31'd0, o_free}, 32'd0);
      cyc(1'b0, 8'h00, 8'h00);
    end
    chk("to_free_t17", {31'd0, o_free}, 32'd1);
    chk("to_flag_t17", {31'd0, o_err_timeout}, 32'd1);
    chk("to_pend_t17", {24'd0, o_pending_mask}, 32'h02);
    cyc(1'b0, 8'h00, 8'h00);
    chkIdle("to_t18");

    // Overrun: a second drive during WAIT is dropped and flagged
    cyc(1'b1, 8'hFF, 8'h00);
    cyc(1'b0, 8'h00, 8'h03);
    chk("ovr_pend_t2", {24'd0, o_pending_mask}, 32'hFC);
    cyc(1'b1, 8'h00, 8'h00);
    chk("ovr_flag_t3", {31'd0, o_err_overrun}, 32'd1);
    chk("ovr_pend_t3", {24'd0, o_pending_mask}, 32'hFC);
    chk("ovr_drive_t3", {24'd0, o_drive}, 32'h00);
    chk("ovr_busy_t3", {31'd0, o_busy}, 32'd1);
    cyc(1'b0, 8'h00, 8'hFC);
    chk("ovr_flag_t4", {31'd0, o_err_overrun}, 32'd0);
    chk("ovr_free_t4", {31'd0, o_free}, 32'd1);
    cyc(1'b0, 8'h00, 8'h00);
    chkIdle("ovr_t5");
    cyc(1'b0, 8'h00, 8'h00);
    chk("ovr_free_t6", {31'd0, o_free}, 32'd0);

    // Reset mid-WAIT aborts silently
    cyc(1'b1, 8'hFF, 8'h00);
    cyc(1'b0, 8'h00, 8'h07);
    cyc(1'b0, 8'h00, 8'h00);
    chk("mid_pend_pre", {24'd0, o_pending_mask}, 32'hF8);
    rstn = 1'b0;
    #1;
    chkIdle("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_nofree", {31'd0, o_free}, 32'd0);
      cyc(1'b0, 8'h00, 8'h00);
    end
    cyc(1'b1, 8'h3C, 8'h00);
    chk("mid_new_drive", {24'd0, o_drive}, 32'h3C);
    chk("mid_new_pend", {24'd0, o_pending_mask}, 32'h3C);
    cyc(1'b0, 8'h00, 8'h3C);
    chk("mid_new_free", {31'd0, o_free}, 32'd1);
    cyc(1'b0, 8'h00, 8'h00);
    chkIdle("mid_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
